// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Groups the arbiter's bus signals into one bundle.
//   writeback   : wb_en, wb_reg, wb_data
//   multi-cycle : mc_valid, mc_ready, mc_reg, mc_data
//   scoreboard  : issue_en, issue_reg, chk_rs1, chk_rs2, chk_rd, busy
//   reg file    : rf_wr_en, rf_wr_reg, rf_wr_data
//   status      : pipe_stall, fifo_level, idle
// Modports: slave  = the arbiter (consumes requests, produces writes/status)
//           master = the surrounding pipeline / testbench
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 2
);
  logic                          wb_en;
  logic [4:0]                    wb_reg;
  logic [31:0]                   wb_data;
  logic                          mc_valid;
  logic                          mc_ready;
  logic [4:0]                    mc_reg;
  logic [31:0]                   mc_data;
  logic                          issue_en;
  logic [4:0]                    issue_reg;
  logic [4:0]                    chk_rs1;
  logic [4:0]                    chk_rs2;
  logic [4:0]                    chk_rd;
  logic                          busy;
  logic                          pipe_stall;
  logic                          rf_wr_en;
  logic [4:0]                    rf_wr_reg;
  logic [31:0]                   rf_wr_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          idle;

  modport slave (
    input  wb_en, wb_reg, wb_data,
    input  mc_valid, mc_reg, mc_data,
    input  issue_en, issue_reg, chk_rs1, chk_rs2, chk_rd,
    output mc_ready, busy, pipe_stall,
    output rf_wr_en, rf_wr_reg, rf_wr_data,
    output fifo_level, idle
  );

  modport master (
    output wb_en, wb_reg, wb_data,
    output mc_valid, mc_reg, mc_data,
    output issue_en, issue_reg, chk_rs1, chk_rs2, chk_rd,
    input  mc_ready, busy, pipe_stall,
    input  rf_wr_en, rf_wr_reg, rf_wr_data,
    input  fifo_level, idle
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between writeback (always wins)
// and a multi-cycle unit whose results wait in a small FIFO. A 32-bit pending
// scoreboard flags registers with an in-flight multi-cycle result.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - regfile_write_arbiter_if.slave (writeback, mc, scoreboard, rf, status)
// Parameters: FIFO_DEPTH (power of two, >= 2), STARVE_LIMIT (guard only)
// Optional feature: define RFWA_STARVE_GUARD_EN to build the starvation guard
// that raises pipe_stall when the FIFO head has waited STARVE_LIMIT cycles.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [4:0]  r_fifo_reg  [FIFO_DEPTH];
  logic [31:0] r_fifo_data [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_pending;
  logic        r_rf_wr_en;
  logic [4:0]  r_rf_wr_reg;
  logic [31:0] r_rf_wr_data;

  logic        w_empty;
  logic        w_full;
  logic        w_wb_eff;
  logic        w_push;
  logic        w_pop;
  logic        w_store;
  logic        w_sel_en;
  logic [4:0]  w_sel_reg;
  logic [31:0] w_sel_data;
  logic        w_mc_commit;
  logic [4:0]  w_mc_reg;
  logic [31:0] w_pend_next;
  logic [4:0]  w_head_reg;
  logic [31:0] w_head_data;

  // Pointers carry an extra wrap bit: equal = empty, only MSB differs = full.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head_reg  = r_fifo_reg[r_rd_ptr[AW-1:0]];
  assign w_head_data = r_fifo_data[r_rd_ptr[AW-1:0]];
  assign w_wb_eff    = bus.wb_en && (bus.wb_reg != 5'd0);
  // Ready looks only at "full": a same-cycle pop never frees a slot for a push.
  assign w_push      = bus.mc_valid && !w_full;

  // Write-slot selection: writeback, else FIFO head, else same-cycle bypass.
  always_comb begin
    w_sel_en    = 1'b0;
    w_sel_reg   = r_rf_wr_reg;
    w_sel_data  = r_rf_wr_data;
    w_pop       = 1'b0;
    w_store     = w_push;
    w_mc_commit = 1'b0;
    w_mc_reg    = 5'd0;
    if (w_wb_eff) begin
      w_sel_en   = 1'b1;
      w_sel_reg  = bus.wb_reg;
      w_sel_data = bus.wb_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_en    = (w_head_reg != 5'd0);
      w_sel_reg   = w_head_reg;
      w_sel_data  = w_head_data;
      w_mc_commit = 1'b1;
      w_mc_reg    = w_head_reg;
    end else if (w_push) begin
      // Bypass: the result goes straight to the write port and is never stored.
      w_store     = 1'b0;
      w_sel_en    = (bus.mc_reg != 5'd0);
      w_sel_reg   = bus.mc_reg;
      w_sel_data  = bus.mc_data;
      w_mc_commit = 1'b1;
      w_mc_reg    = bus.mc_reg;
    end else begin
      w_sel_en = 1'b0;
    end
  end

  // Scoreboard update: clear on mc commit, then set on issue so set wins.
  always_comb begin
    w_pend_next = r_pending;
    if (w_mc_commit) begin
      w_pend_next[w_mc_reg] = 1'b0;
    end else begin
      w_pend_next = w_pend_next;
    end
    if (bus.issue_en) begin
      w_pend_next[bus.issue_reg] = 1'b1;
    end else begin
      w_pend_next = w_pend_next;
    end
    w_pend_next[0] = 1'b0;
  end

  // Control state: pointers, scoreboard and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pending    <= 32'd0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_reg  <= 5'd0;
      r_rf_wr_data <= 32'd0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)   r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      r_pending    <= w_pend_next;
      r_rf_wr_en   <= w_sel_en;
      r_rf_wr_reg  <= w_sel_reg;
      r_rf_wr_data <= w_sel_data;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_fifo_reg[r_wr_ptr[AW-1:0]]  <= bus.mc_reg;
      r_fifo_data[r_wr_ptr[AW-1:0]] <= bus.mc_data;
    end
  end

  assign bus.mc_ready   = !w_full;
  assign bus.busy       = r_pending[bus.chk_rs1] | r_pending[bus.chk_rs2] |
                          r_pending[bus.chk_rd];
  assign bus.idle       = w_empty && (r_pending == 32'd0) && !r_rf_wr_en;
  assign bus.fifo_level = r_wr_ptr - r_rd_ptr;
  assign bus.rf_wr_en   = r_rf_wr_en;
  assign bus.rf_wr_reg  = r_rf_wr_reg;
  assign bus.rf_wr_data = r_rf_wr_data;

`ifdef RFWA_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_pipe_stall;

  // Wait counter saturates at the limit so the stall holds until a pop.
  always_comb begin
    w_cnt_next = {CW{1'b0}};
    if (!w_empty && !w_pop) begin
      if (r_starve_cnt == CW'(STARVE_LIMIT)) begin
        w_cnt_next = r_starve_cnt;
      end else begin
        w_cnt_next = r_starve_cnt + CW'(1);
      end
    end else begin
      w_cnt_next = {CW{1'b0}};
    end
  end

  // Starvation counter and registered stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= {CW{1'b0}};
      r_pipe_stall <= 1'b0;
    end else begin
      r_starve_cnt <= w_cnt_next;
      r_pipe_stall <= (w_cnt_next == CW'(STARVE_LIMIT));
    end
  end

  assign bus.pipe_stall = r_pipe_stall;
`else
  assign bus.pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed stimulus against a queue/array model of the arbiter; a negedge
// process compares every cycle, and literal expectations pin key moments.
// Define RFWA_STARVE_GUARD_EN to also exercise the starvation guard.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus();

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: FIFO as a queue of {reg, data}, pending bits, expected write.
  logic [36:0] m_q[$];
  logic [31:0] m_pend;
  logic        m_en;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_wait;
  logic        m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend  = 32'd0;
    m_en    = 1'b0;
    m_reg   = 5'd0;
    m_data  = 32'd0;
    m_wait  = 0;
    m_stall = 1'b0;
  endtask

  task automatic model_commit(input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0) begin
      m_en     = 1'b1;
      m_reg    = r;
      m_data   = d;
      m_pend[r] = 1'b0;
    end
  endtask

  // One clock of the arbiter's rules, evaluated with the inputs at the edge.
  task automatic model_step();
    logic        push;
    logic        popped;
    int          pre;
    logic [36:0] e;
    if (rst) begin
      model_reset();
      return;
    end
    pre    = m_q.size();
    push   = bus.mc_valid && (pre < DEPTH);
    popped = 1'b0;
    m_en   = 1'b0;
    if (bus.wb_en && bus.wb_reg != 5'd0) begin
      m_en   = 1'b1;
      m_reg  = bus.wb_reg;
      m_data = bus.wb_data;
    end else if (pre > 0) begin
      e      = m_q.pop_front();
      popped = 1'b1;
      model_commit(e[36:32], e[31:0]);
    end else if (push) begin
      model_commit(bus.mc_reg, bus.mc_data);
      push = 1'b0;
    end
    if (push) m_q.push_back({bus.mc_reg, bus.mc_data});
    if (bus.issue_en && bus.issue_reg != 5'd0) m_pend[bus.issue_reg] = 1'b1;
    if (pre > 0 && !popped) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else                    m_wait = 0;
    m_stall = (m_wait >= LIMIT);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("rf_wr_en", bus.rf_wr_en, m_en);
      if (m_en) begin
        chk("rf_wr_reg", bus.rf_wr_reg, m_reg);
        chk("rf_wr_data", bus.rf_wr_data, m_data);
      end
      chk("mc_ready", bus.mc_ready, m_q.size() < DEPTH);
      chk("fifo_level", bus.fifo_level, m_q.size());
      chk("idle", bus.idle, (m_q.size() == 0) && (m_pend == 32'd0) && !m_en);
      chk("busy", bus.busy, m_pend[bus.chk_rs1] | m_pend[bus.chk_rs2] | m_pend[bus.chk_rd]);
`ifdef RFWA_STARVE_GUARD_EN
      chk("pipe_stall", bus.pipe_stall, m_stall);
`else
      chk("pipe_stall", bus.pipe_stall, 1'b0);
`endif
    end
  end

  initial begin
    int n;
    bus.wb_en = 1'b0;    bus.wb_reg = 5'd0;    bus.wb_data = 32'd0;
    bus.mc_valid = 1'b0; bus.mc_reg = 5'd0;    bus.mc_data = 32'd0;
    bus.issue_en = 1'b0; bus.issue_reg = 5'd0;
    bus.chk_rs1 = 5'd0;  bus.chk_rs2 = 5'd0;   bus.chk_rd = 5'd0;
    model_reset();

    // Reset state
    repeat (3) cyc();
    chk("rst_rf_wr_en", bus.rf_wr_en, 1'b0);
    chk("rst_mc_ready", bus.mc_ready, 1'b1);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_fifo_level", bus.fifo_level, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Bypass into an empty FIFO
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd5; bus.mc_data = 32'hDEADBEEF;
    cyc();
    bus.mc_valid = 1'b0;
    chk("byp_en", bus.rf_wr_en, 1'b1);
    chk("byp_reg", bus.rf_wr_reg, 32'd5);
    chk("byp_data", bus.rf_wr_data, 32'hDEADBEEF);
    chk("byp_level", bus.fifo_level, 32'd0);
    cyc();

    // Writeback priority while the FIFO fills
    bus.wb_en = 1'b1; bus.wb_reg = 5'd1; bus.wb_data = 32'h11;
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd6; bus.mc_data = 32'h66;
    cyc();
    bus.mc_reg = 5'd7; bus.mc_data = 32'h77; bus.wb_data = 32'h12;
    cyc();
    chk("fill_level", bus.fifo_level, 32'd2);
    chk("fill_ready", bus.mc_ready, 1'b0);
    chk("fill_wb_reg", bus.rf_wr_reg, 32'd1);
    bus.mc_reg = 5'd8; bus.mc_data = 32'h88; bus.wb_data = 32'h13;
    cyc();
    bus.wb_data = 32'h14;
    cyc();
    bus.wb_en = 1'b0;
    cyc();
    chk("drain_x6", bus.rf_wr_reg, 32'd6);
    cyc();
    chk("drain_x7", bus.rf_wr_reg, 32'd7);
    bus.mc_valid = 1'b0;
    cyc();
    chk("drain_x8", bus.rf_wr_reg, 32'd8);
    chk("drain_x8_data", bus.rf_wr_data, 32'h88);
    cyc();

    // Scoreboard set / clear / set-wins
    bus.issue_en = 1'b1; bus.issue_reg = 5'd9; bus.chk_rs1 = 5'd9;
    cyc();
    bus.issue_en = 1'b0;
    chk("sb_busy_set", bus.busy, 1'b1);
    cyc();
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd9; bus.mc_data = 32'h99;
    cyc();
    bus.mc_valid = 1'b0;
    chk("sb_busy_clr", bus.busy, 1'b0);
    bus.issue_en = 1'b1;
    cyc();
    bus.mc_valid = 1'b1; bus.mc_data = 32'h9A;
    cyc();
    bus.mc_valid = 1'b0; bus.issue_en = 1'b0;
    chk("sb_set_wins", bus.busy, 1'b1);
    bus.mc_valid = 1'b1; bus.mc_data = 32'h9B;
    cyc();
    bus.mc_valid = 1'b0;
    chk("sb_final_clr", bus.busy, 1'b0);
    cyc();

    // x0 handling
    bus.wb_en = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h22;
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd3; bus.mc_data = 32'h33;
    cyc();
    bus.mc_valid = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'h0BAD;
    cyc();
    chk("x0_pop_en", bus.rf_wr_en, 1'b1);
    chk("x0_pop_reg", bus.rf_wr_reg, 32'd3);
    bus.wb_en = 1'b0;
    bus.issue_en = 1'b1; bus.issue_reg = 5'd0; bus.chk_rs1 = 5'd0;
    cyc();
    bus.issue_en = 1'b0;
    chk("x0_issue_busy", bus.busy, 1'b0);
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd0; bus.mc_data = 32'h55;
    cyc();
    bus.mc_valid = 1'b0;
    chk("x0_mc_no_write", bus.rf_wr_en, 1'b0);
    cyc();

`ifdef RFWA_STARVE_GUARD_EN
    // Starvation guard: head waits behind continuous writeback
    bus.wb_en = 1'b1; bus.wb_reg = 5'd1; bus.wb_data = 32'h44;
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd4; bus.mc_data = 32'h4444;
    cyc();
    bus.mc_valid = 1'b0;
    n = 0;
    while (!bus.pipe_stall && n < 10) begin
      cyc();
      n++;
    end
    chk("guard_cycles", n, 32'd4);
    bus.wb_en = 1'b0;
    cyc();
    chk("guard_pop_reg", bus.rf_wr_reg, 32'd4);
    chk("guard_stall_off", bus.pipe_stall, 1'b0);
    cyc();
`else
    n = 0;
`endif

    // Asynchronous reset in mid-operation
    bus.wb_en = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h2;
    bus.mc_valid = 1'b1; bus.mc_reg = 5'd3; bus.mc_data = 32'h3;
    bus.issue_en = 1'b1; bus.issue_reg = 5'd10; bus.chk_rs1 = 5'd10;
    cyc();
    bus.wb_en = 1'b0; bus.mc_valid = 1'b0; bus.issue_en = 1'b0;
    chk("pre_rst_level", bus.fifo_level, 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_level", bus.fifo_level, 32'd0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_idle", bus.idle, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
